map_read_arbiter: RTL and testbench



---
 rtl/map_read_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_map_read_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_read_arbiter.sv
// Shares the maze map ROM read port between NREQ cell clients and the video renderer.
// Optional anti-starvation guard for clients: define MAP_ARB_STARVE_GUARD_EN.
module map_read_arbiter #(
    parameter int NREQ       = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [5*NREQ-1:0]        req_row,
    input  logic [5*NREQ-1:0]        req_col,
    output logic [NREQ-1:0]          gnt,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     rsp_wall,
    input  logic                     vid_req,
    input  logic [4:0]               vid_row,
    output logic                     vid_gnt,
    output logic                     vid_valid,
    output logic [31:0]              vid_bits,
    output logic [4:0]               map_row,
    input  logic [31:0]              map_bits
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] win_id_s;
    logic           cli_any_s;
    logic           vid_mask_s;

    logic [4:0]     map_row_q, map_row_d;
    logic           s1_valid_q, s1_valid_d;
    logic           s1_vid_q, s1_vid_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic [4:0]     s1_col_q, s1_col_d;

    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_wall_q, rsp_wall_d;
    logic           vid_valid_q, vid_valid_d;
    logic [31:0]    vid_bits_q, vid_bits_d;

`ifdef MAP_ARB_STARVE_GUARD_EN
    localparam int SCW = $clog2(STARVE_MAX + 1);
    logic [SCW-1:0] starve_cnt_q, starve_cnt_d;

    // Video yields exactly one slot once it has won STARVE_MAX times over a waiting client.
    assign vid_mask_s = (starve_cnt_q == SCW'(STARVE_MAX)) && (|req);

    // Consecutive video wins while a client waits.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!(|req)) begin
            starve_cnt_d = '0;
        end else if (vid_gnt) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end else if (cli_any_s) begin
            starve_cnt_d = '0;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign vid_mask_s = 1'b0;
`endif

    // Round-robin search over client requests, starting at rr_ptr.
    always_comb begin : rr_search
        int idx;
        idx       = 0;
        cli_any_s = 1'b0;
        win_id_s  = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!cli_any_s && req[idx]) begin
                cli_any_s = 1'b1;
                win_id_s  = IDW'(idx);
            end else begin
                win_id_s  = win_id_s;
            end
        end
    end

    // Grant selection: video first unless masked, else the round-robin winner.
    always_comb begin
        gnt     = '0;
        vid_gnt = 1'b0;
        if (vid_req && !vid_mask_s) begin
            vid_gnt = 1'b1;
        end else if (cli_any_s) begin
            gnt[win_id_s] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

    // Pipeline next state: stage 1 latches the accepted lookup, stage 2 forms the result.
    always_comb begin
        map_row_d   = map_row_q;
        s1_valid_d  = 1'b0;
        s1_vid_d    = s1_vid_q;
        s1_id_d     = s1_id_q;
        s1_col_d    = s1_col_q;
        rr_ptr_d    = rr_ptr_q;
        if (vid_gnt) begin
            map_row_d  = vid_row;
            s1_valid_d = 1'b1;
            s1_vid_d   = 1'b1;
        end else if (cli_any_s) begin
            map_row_d  = req_row[5*win_id_s +: 5];
            s1_valid_d = 1'b1;
            s1_vid_d   = 1'b0;
            s1_id_d    = win_id_s;
            s1_col_d   = req_col[5*win_id_s +: 5];
            rr_ptr_d   = (win_id_s == IDW'(NREQ-1)) ? '0 : win_id_s + 1'b1;
        end else begin
            s1_valid_d = 1'b0;
        end

        rsp_valid_d = s1_valid_q && !s1_vid_q;
        vid_valid_d = s1_valid_q && s1_vid_q;
        rsp_id_d    = rsp_id_q;
        rsp_wall_d  = rsp_wall_q;
        vid_bits_d  = vid_bits_q;
        if (rsp_valid_d) begin
            rsp_id_d   = s1_id_q;
            // Column 0 lives in the MSB of the row word.
            rsp_wall_d = map_bits[5'd31 - s1_col_q];
        end else if (vid_valid_d) begin
            vid_bits_d = map_bits;
        end else begin
            rsp_id_d   = rsp_id_q;
        end
    end

    // Pipeline and arbitration state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            map_row_q   <= 5'd0;
            s1_valid_q  <= 1'b0;
            s1_vid_q    <= 1'b0;
            s1_id_q     <= '0;
            s1_col_q    <= 5'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_wall_q  <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_bits_q  <= 32'd0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            map_row_q   <= map_row_d;
            s1_valid_q  <= s1_valid_d;
            s1_vid_q    <= s1_vid_d;
            s1_id_q     <= s1_id_d;
            s1_col_q    <= s1_col_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_wall_q  <= rsp_wall_d;
            vid_valid_q <= vid_valid_d;
            vid_bits_q  <= vid_bits_d;
        end
    end

    assign map_row   = map_row_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_wall  = rsp_wall_q;
    assign vid_valid = vid_valid_q;
    assign vid_bits  = vid_bits_q;

endmodule

// File: tb/tb_map_read_arbiter.sv
// Scoreboard bench for map_read_arbiter with a behavioural map ROM.
module tb_map_read_arbiter;
    localparam int NREQ       = 4;
    localparam int IDW        = 2;
    localparam int STARVE_MAX = 8;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NREQ-1:0]     req;
    logic [5*NREQ-1:0]   req_row;
    logic [5*NREQ-1:0]   req_col;
    logic [NREQ-1:0]     gnt;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic                rsp_wall;
    logic                vid_req;
    logic [4:0]          vid_row;
    logic                vid_gnt;
    logic                vid_valid;
    logic [31:0]         vid_bits;
    logic [4:0]          map_row;
    logic [31:0]         map_bits;

    map_read_arbiter #(.NREQ(NREQ), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_row(req_row), .req_col(req_col),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_wall(rsp_wall),
        .vid_req(vid_req), .vid_row(vid_row), .vid_gnt(vid_gnt), .vid_valid(vid_valid),
        .vid_bits(vid_bits), .map_row(map_row), .map_bits(map_bits)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] map_word(input logic [4:0] r);
        case (r)
            5'd2:    return 32'h8000_8001;
            5'd28:   return 32'hFFFF_FFFF;
            default: return 32'h9E37_79B9 ^ {r, r, r, r, r, r, 2'b01};
        endcase
    endfunction

    assign map_bits = map_word(map_row);

    typedef struct {
        logic           is_vid;
        logic [IDW-1:0] id;
        logic           wall;
        logic [31:0]    bits;
        int             due;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    int   m_rr     = 0;
    int   m_starve = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: check results, predict the grant, push the expected result of each accept.
    always @(negedge clk) begin : sb_mon
        exp_t            e;
        logic [NREQ-1:0] eg;
        logic            ev;
        logic            any;
        int              w;
        int              idx;
        logic [31:0]     wd;
        logic [4:0]      col;
        cyc++;
        if (!reset_n) begin
            sb_q.delete();
            m_rr     = 0;
            m_starve = 0;
        end else begin
            while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                check_eq("missing_result", 64'd0, 64'd1);
                void'(sb_q.pop_front());
            end
            if (rsp_valid || vid_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_valid", {62'd0, rsp_valid, vid_valid}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("result_latency", 64'(cyc), 64'(e.due));
                    check_eq("result_kind", {62'd0, rsp_valid, vid_valid}, {62'd0, ~e.is_vid, e.is_vid});
                    if (e.is_vid) begin
                        check_eq("vid_bits", 64'(vid_bits), 64'(e.bits));
                    end else begin
                        check_eq("rsp_id", 64'(rsp_id), 64'(e.id));
                        check_eq("rsp_wall", 64'(rsp_wall), 64'(e.wall));
                    end
                end
            end
            ev  = vid_req;
            any = 1'b0;
            eg  = '0;
            w   = 0;
`ifdef MAP_ARB_STARVE_GUARD_EN
            if (m_starve == STARVE_MAX && (|req)) ev = 1'b0;
`endif
            if (!ev) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_rr + k) % NREQ;
                    if (!any && req[idx]) begin
                        any = 1'b1;
                        w   = idx;
                    end
                end
                if (any) eg[w] = 1'b1;
            end
            check_eq("grant", {59'd0, vid_gnt, gnt}, {59'd0, ev, eg});
            if (ev) begin
                sb_q.push_back('{1'b1, '0, 1'b0, map_word(vid_row), cyc + 2});
            end else if (any) begin
                wd  = map_word(req_row[5*w +: 5]);
                col = req_col[5*w +: 5];
                sb_q.push_back('{1'b0, IDW'(w), wd[31 - col], 32'd0, cyc + 2});
                m_rr = (w + 1) % NREQ;
            end
            if (!(|req)) m_starve = 0;
            else if (ev) m_starve++;
            else if (any) m_starve = 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cli(input int i, input logic [4:0] r, input logic [4:0] c);
        req[i]          = 1'b1;
        req_row[5*i +: 5] = r;
        req_col[5*i +: 5] = c;
    endtask

    initial begin : main
        int              first;
        int              seen;
        logic [31:0]     hist;
        logic [NREQ-1:0] acc;
        logic            vacc;
        reset_n = 1'b0; req = '0; req_row = '0; req_col = '0; vid_req = 1'b0; vid_row = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("reset_rsp_id", 64'(rsp_id), 64'd0);
        check_eq("reset_rsp_wall", 64'(rsp_wall), 64'd0);
        check_eq("reset_vid_valid", 64'(vid_valid), 64'd0);
        check_eq("reset_vid_bits", 64'(vid_bits), 64'd0);
        check_eq("reset_map_row", 64'(map_row), 64'd0);
        next_cycle();
        reset_n = 1'b1;

        // Single client lookups: open cell then wall cell.
        set_cli(0, 5'd2, 5'd4);
        @(negedge clk);
        check_eq("t1_gnt", 64'(gnt), 64'h1);
        next_cycle();
        req = '0;
        repeat (3) next_cycle();
        check_eq("t1_wall_open", 64'(rsp_wall), 64'd0);
        set_cli(0, 5'd2, 5'd16);
        next_cycle();
        req = '0;
        repeat (3) next_cycle();
        check_eq("t1_wall_set", 64'(rsp_wall), 64'd1);

        // All clients held: rotating grants.
        for (int i = 0; i < NREQ; i++) set_cli(i, 5'(i + 3), 5'(i * 7));
        repeat (5) next_cycle();
        req = '0;
        repeat (3) next_cycle();

        // Video beats a waiting client.
        vid_req = 1'b1; vid_row = 5'h1C;
        set_cli(2, 5'd9, 5'd3);
        @(negedge clk);
        check_eq("t3_vid_gnt", 64'(vid_gnt), 64'd1);
        check_eq("t3_gnt", 64'(gnt), 64'd0);
        next_cycle();
        vid_req = 1'b0;
        next_cycle();
        req = '0;
        repeat (3) next_cycle();
        check_eq("t3_vid_bits", 64'(vid_bits), 64'hFFFF_FFFF);

        // Idle: no pulses, address holds the last client row.
        repeat (10) next_cycle();
        check_eq("t6_map_row", 64'(map_row), 64'd9);

        // Video held against a waiting client.
        vid_req = 1'b1; vid_row = 5'd7;
        set_cli(1, 5'd28, 5'd0);
        first = -1; seen = 0; hist = '0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            hist[c] = vid_gnt;
            if (gnt[1]) begin
                seen++;
                if (first < 0) first = c;
            end
            next_cycle();
        end
`ifdef MAP_ARB_STARVE_GUARD_EN
        check_eq("t4_first_client", 64'(first), 64'(STARVE_MAX));
        check_eq("t4_vid_resumes", 64'(hist[STARVE_MAX+1]), 64'd1);
`else
        check_eq("t4_no_client", 64'(seen), 64'd0);
`endif
        vid_req = 1'b0;
        next_cycle();
        req = '0;
        repeat (3) next_cycle();

        // Reset in flight discards the lookup.
        set_cli(3, 5'd2, 5'd16);
        @(negedge clk);
        check_eq("t5_gnt", 64'(gnt), 64'h8);
        next_cycle();
        req = '0;
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("t5_vid_valid", 64'(vid_valid), 64'd0);
        check_eq("t5_map_row", 64'(map_row), 64'd0);
        next_cycle();
        reset_n = 1'b1;
        repeat (4) next_cycle();

        // Random traffic honouring the hold-until-accepted rule.
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            acc  = req & gnt;
            vacc = vid_req & vid_gnt;
            next_cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] || !req[i]) begin
                    req[i]            = ($urandom_range(0, 2) != 0);
                    req_row[5*i +: 5] = 5'($urandom);
                    req_col[5*i +: 5] = 5'($urandom);
                end
            end
            if (vacc || !vid_req) begin
                vid_req = ($urandom_range(0, 3) == 0);
                vid_row = 5'($urandom);
            end
        end
        req = '0; vid_req = 1'b0;
        repeat (5) next_cycle();
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
